scm_fifo_ctrl: RTL and testbench
================================

// Module: scm_fifo_ctrl
// PURPOSE
// Valid/ready FIFO controller that sits directly upstream of a 1-read/1-write
// flip-flop register file. It owns the write/read pointers, the occupancy count
// and the handshakes, and drives the register-file write and read ports.
// The storage read address is registered inside the storage, so ReadData follows
// the address captured at the previous edge. The controller keeps that address
// locked on the FIFO head, so the head word is always visible on mem_rdata.
// PARAMETERS
// ADDR_WIDTH  5   storage address width; FIFO depth DEPTH = 2**ADDR_WIDTH entries
// DATA_WIDTH  32  word width
// AF_THRESH   DEPTH-2  almost_full asserts when count >= AF_THRESH
// PORTS
// clk        in   1             clock, rising edge
// rst_n      in   1             asynchronous active-low reset
// clear_i    in   1             synchronous flush: empties the FIFO
// in_valid   in   1             push request
// in_ready   out  1             push accepted when in_valid & in_ready
// in_data    in   DATA_WIDTH    push data
// out_valid  out  1             head word valid
// out_ready  in   1             pop accepted when out_valid & out_ready
// out_data   out  DATA_WIDTH    head word (= mem_rdata)
// count      out  ADDR_WIDTH+1  occupancy 0..DEPTH
// almost_full out 1             count >= AF_THRESH
// mem_we     out  1             to storage WriteEnable
// mem_waddr  out  ADDR_WIDTH    to storage WriteAddr
// mem_wdata  out  DATA_WIDTH    to storage WriteData
// mem_re     out  1             to storage ReadEnable
// mem_raddr  out  ADDR_WIDTH    to storage ReadAddr
// mem_rdata  in   DATA_WIDTH    from storage ReadData
// BEHAVIOUR
// - Pointers
//   - wptr and rptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
//   - empty = (wptr == rptr); full = MSBs differ and low bits are equal.
//   - Wrap from DEPTH-1 to 0 is natural binary overflow.
// - Reset (async, rst_n = 0)
//   - wptr = rptr = 0, count = 0, init_q = 1.
//   - Outputs: in_ready = 0, out_valid = 0, almost_full = 0 (also when AF_THRESH = 0),
//     mem_we = 0, mem_re = 1, mem_raddr = 0.
// - Init
//   - init_q clears on the first clock edge after reset release.
//   - That edge loads storage read address 0, which is not reset inside the storage.
//   - While init_q = 1: in_ready = 0 and out_valid = 0.
// - Push
//   - in_ready = !full & !init_q.
//   - On in_valid & in_ready: mem_we = 1, mem_waddr = wptr[ADDR_WIDTH-1:0],
//     mem_wdata = in_data, and wptr increments at the edge.
//   - mem_we, mem_waddr and mem_wdata are combinational from in_valid/in_ready,
//     in_data and wptr.
// - Pop
//   - out_valid = !empty & !init_q; out_data = mem_rdata.
//   - On out_valid & out_ready: rptr increments, mem_re = 1, mem_raddr = (rptr+1) low bits.
//   - The next head word is therefore on mem_rdata the following cycle: zero-bubble
//     back-to-back pops.
// - mem_re is asserted only on pop, clear or init_q; otherwise 0, so the storage holds its address.
// - Latency: a word pushed into an empty FIFO at edge t gives out_valid = 1 in cycle t+1,
//   with the correct data, because storage read is combinational from the array.
// - Simultaneous push and pop: both pointers advance and count is unchanged.
// - Full: in_ready = 0 even if a pop occurs in the same cycle. There is no
//   combinational ready->ready path.
// - Empty: no pop is possible; push-and-pop in the same cycle cannot happen.
// - count
//   - count = wptr - rptr, registered; +1 on push only, -1 on pop only.
//   - almost_full is registered, derived from the next-state count.
// - clear_i
//   - Has priority over push and pop in the same cycle. The push is not written
//     (mem_we = 0) and in_ready = 0 that cycle.
//   - Sets wptr = rptr = 0 and count = 0.
//   - Drives mem_re = 1 with mem_raddr = 0.
//   - Storage contents are untouched.
// - Reset asserted mid-operation: all state returns to the reset values immediately;
//   queued data is lost.
// TESTING
// - Reset release -> cycle 0: mem_re = 1, mem_raddr = 0, in_ready = 0; cycle 1: in_ready = 1, out_valid = 0, count = 0.
// - Push 0xA5 into empty FIFO, out_ready = 0 -> next cycle out_valid = 1, out_data = 0xA5, count = 1.
// - Fill 32 words (ADDR_WIDTH = 5) -> in_ready = 0 at count = 32, almost_full = 1 from count = 30; a push attempted while full is not written.
// - Stream 100 words with in_valid = out_ready = 1 -> count stays constant, pointers wrap past 31, output order exact, no bubbles.
// - Full FIFO plus pop and push attempt in same cycle -> pop taken, push refused, count = 31.
// - clear_i with a push pending at count = 5 -> count = 0, out_valid = 0, mem_we = 0, mem_raddr = 0; then push 0x1 -> out_data = 0x1.

Source files
------------

// File: rtl/scm_fifo_ctrl.sv
// scm_fifo_ctrl
// Valid/ready FIFO controller for a 1R/1W flip-flop register file whose read
// address is registered inside the storage. The controller owns the pointers,
// occupancy count and handshakes. It keeps the storage read address parked on
// the FIFO head, so the head word is always present on mem_rdata.
module scm_fifo_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] AF_LVL  = (ADDR_WIDTH+1)'(AF_THRESH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [ADDR_WIDTH:0] wptr_r;
    logic [ADDR_WIDTH:0] rptr_r;
    logic [ADDR_WIDTH:0] count_r;
    logic                init_r;
    logic                almost_full_r;

    logic                empty_s;
    logic                full_s;
    logic                push_s;
    logic                pop_s;
    logic [ADDR_WIDTH:0] rptr_inc_s;
    logic [ADDR_WIDTH:0] count_next_s;
    logic                almost_full_next_s;

    // Status flags, handshakes and the storage port controls.
    always_comb begin
        empty_s    = (wptr_r == rptr_r);
        full_s     = (wptr_r[ADDR_WIDTH] != rptr_r[ADDR_WIDTH]) &&
                     (wptr_r[ADDR_WIDTH-1:0] == rptr_r[ADDR_WIDTH-1:0]);
        rptr_inc_s = rptr_r + PTR_ONE;

        // Ready depends only on state and the flush, never on out_ready.
        in_ready   = !full_s && !init_r && !clear_i;
        out_valid  = !empty_s && !init_r;
        push_s     = in_valid && in_ready;
        pop_s      = out_valid && out_ready && !clear_i;

        mem_we     = push_s;
        mem_waddr  = wptr_r[ADDR_WIDTH-1:0];

        // Read address only moves on pop, flush or the post-reset load; it
        // otherwise holds, so the storage keeps presenting the head word.
        mem_re     = clear_i || pop_s || init_r;
        if (clear_i) begin
            mem_raddr = '0;
        end else if (pop_s) begin
            mem_raddr = rptr_inc_s[ADDR_WIDTH-1:0];
        end else begin
            mem_raddr = rptr_r[ADDR_WIDTH-1:0];
        end
    end

    // Next occupancy and the almost-full flag derived from it.
    always_comb begin
        count_next_s = count_r;
        if (clear_i) begin
            count_next_s = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + PTR_ONE;
                2'b01:   count_next_s = count_r - PTR_ONE;
                default: count_next_s = count_r;
            endcase
        end
        almost_full_next_s = (count_next_s >= AF_LVL);
    end

    // Pointer, count, init and almost-full state; flush has top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r        <= '0;
            rptr_r        <= '0;
            count_r       <= '0;
            init_r        <= 1'b1;
            almost_full_r <= 1'b0;
        end else begin
            init_r        <= 1'b0;
            count_r       <= count_next_s;
            almost_full_r <= almost_full_next_s;
            if (clear_i) begin
                wptr_r <= '0;
                rptr_r <= '0;
            end else begin
                if (push_s) begin
                    wptr_r <= wptr_r + PTR_ONE;
                end else begin
                    wptr_r <= wptr_r;
                end
                if (pop_s) begin
                    rptr_r <= rptr_inc_s;
                end else begin
                    rptr_r <= rptr_r;
                end
            end
        end
    end

    assign mem_wdata   = in_data;
    assign out_data    = mem_rdata;
    assign count       = count_r;
    assign almost_full = almost_full_r;

endmodule

// File: tb/tb_scm_fifo_ctrl.sv
// Directed testbench for scm_fifo_ctrl with a behavioural register-file model
// (registered read address, combinational array read).
module tb_scm_fifo_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_i = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          almost_full;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] raddr_q;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] head;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Storage model: write and read-address capture at the clock edge.
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (mem_re) raddr_q <= mem_raddr;
    end
    assign mem_rdata = mem[raddr_q];

    scm_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .almost_full(almost_full),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_af", almost_full, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_re", mem_re, 1);
        check_eq("rst_mem_raddr", mem_raddr, 0);

        // Release: cycle 0 still initialising, cycle 1 ready
        rst_n = 1'b1;
        #1;
        check_eq("c0_mem_re", mem_re, 1);
        check_eq("c0_mem_raddr", mem_raddr, 0);
        check_eq("c0_in_ready", in_ready, 0);
        tick();
        check_eq("c1_in_ready", in_ready, 1);
        check_eq("c1_out_valid", out_valid, 0);
        check_eq("c1_count", count, 0);
        check_eq("c1_mem_re", mem_re, 0);

        // Push 0xA5 into empty FIFO
        in_valid = 1'b1; in_data = 32'h0000_00A5;
        #1;
        check_eq("push_we", mem_we, 1);
        check_eq("push_waddr", mem_waddr, 0);
        check_eq("push_wdata", mem_wdata, 32'hA5);
        tick();
        in_valid = 1'b0;
        #1;
        check_eq("a5_valid", out_valid, 1);
        check_eq("a5_data", out_data, 32'hA5);
        check_eq("a5_count", count, 1);

        // Pop it: read address jumps to the next slot
        out_ready = 1'b1;
        #1;
        check_eq("pop_re", mem_re, 1);
        check_eq("pop_raddr", mem_raddr, 1);
        tick();
        out_ready = 1'b0;
        check_eq("pop_valid", out_valid, 0);
        check_eq("pop_count", count, 0);

        // Fill to 32 entries (pointers start at slot 1)
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1; in_data = 32'h100 + i;
            #1;
            check_eq("fill_ready", in_ready, 1);
            tick();
            exp_q.push_back(32'h100 + i);
            check_eq("fill_count", count, i + 1);
            check_eq("fill_af", almost_full, (i + 1) >= 30);
        end
        check_eq("full_valid", out_valid, 1);
        // Push attempt while full must be refused and not written
        in_data = 32'hDEAD_BEEF;
        #1;
        check_eq("full_ready", in_ready, 0);
        check_eq("full_we", mem_we, 0);
        tick();
        in_valid = 1'b0;
        check_eq("full_count", count, 32);
        check_eq("full_head", out_data, 32'h100);

        // Full with pop and push in the same cycle: pop only
        in_valid = 1'b1; out_ready = 1'b1; in_data = 32'hBAD0_0001;
        #1;
        check_eq("fpp_ready", in_ready, 0);
        check_eq("fpp_data", out_data, exp_q[0]);
        tick();
        head = exp_q.pop_front();
        check_eq("fpp_count", count, 31);
        check_eq("fpp_next", out_data, 32'h101);

        // Stream 100 words with push and pop every cycle
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h2000 + i;
            #1;
            check_eq("str_ready", in_ready, 1);
            check_eq("str_valid", out_valid, 1);
            check_eq("str_data", out_data, exp_q[0]);
            tick();
            head = exp_q.pop_front();
            exp_q.push_back(32'h2000 + i);
            check_eq("str_count", count, 31);
        end

        // Drain
        in_valid = 1'b0;
        for (int i = 0; i < 64 && exp_q.size() > 0; i++) begin
            out_ready = 1'b1;
            #1;
            check_eq("drn_valid", out_valid, 1);
            check_eq("drn_data", out_data, exp_q[0]);
            tick();
            head = exp_q.pop_front();
        end
        out_ready = 1'b0;
        check_eq("drn_empty", out_valid, 0);
        check_eq("drn_count", count, 0);
        check_eq("drn_af", almost_full, 0);

        // Clear with a push pending at count 5
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 32'h300 + i;
            tick();
        end
        check_eq("pre_clr_count", count, 5);
        clear_i = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h0000_0777;
        #1;
        check_eq("clr_ready", in_ready, 0);
        check_eq("clr_we", mem_we, 0);
        check_eq("clr_re", mem_re, 1);
        check_eq("clr_raddr", mem_raddr, 0);
        tick();
        clear_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check_eq("clr_count", count, 0);
        check_eq("clr_valid", out_valid, 0);
        in_valid = 1'b1; in_data = 32'h1;
        #1;
        check_eq("clr_push_waddr", mem_waddr, 0);
        tick();
        in_valid = 1'b0;
        check_eq("clr_push_valid", out_valid, 1);
        check_eq("clr_push_data", out_data, 32'h1);
        check_eq("clr_push_count", count, 1);

        // Asynchronous reset mid-operation
        in_valid = 1'b1; in_data = 32'h55;
        tick();
        check_eq("pre_rst_count", count, 2);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("arst_count", count, 0);
        check_eq("arst_valid", out_valid, 0);
        check_eq("arst_ready", in_ready, 0);
        check_eq("arst_re", mem_re, 1);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_ready", in_ready, 1);
        check_eq("post_rst_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
